// File: rtl/scr1_csr_unit.sv
// Machine-mode CSR file: CSRRW/CSRRS/CSRRC access port, trap/mret state updates,
// 64-bit mcycle/minstret counters, interrupt pending flag and trap vector to fetch.
module scr1_csr_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     HART_ID   = 0,
    parameter logic [31:0]     MISA_VAL  = 32'h4000_0100,
    parameter int unsigned     ARCH_ID   = 0,
    parameter int unsigned     IMP_ID    = 1,
    parameter logic [XLEN-1:0] MTVEC_RST = {XLEN{1'b0}}
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            csr_req_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_ack_o,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic            instret_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam logic [1:0]  OP_READ = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
    localparam logic [11:0] ADDR_MISA       = 12'h301;
    localparam logic [11:0] ADDR_MIE        = 12'h304;
    localparam logic [11:0] ADDR_MTVEC      = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] ADDR_MEPC       = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE     = 12'h342;
    localparam logic [11:0] ADDR_MIP        = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID  = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID    = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID     = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID    = 12'hF14;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return v & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

    // Reserved MODE encodings (bit 1 set) leave the previous MODE in place.
    function automatic logic [XLEN-1:0] mtvec_warl(input logic [1:0] old_mode,
                                                   input logic [XLEN-1:0] new_v);
        return {new_v[XLEN-1:2], (new_v[1] ? old_mode : new_v[1:0])};
    endfunction

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_meie_q, mie_meie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mip_meip_q, mip_meip_d;
    logic            mip_mtip_q, mip_mtip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [31:0]     mcounteren_q, mcounteren_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;
    logic            ack_q, ack_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            illegal_q, illegal_d;
    logic            irq_pending_q, irq_pending_d;

    logic [XLEN-1:0] csr_old_s;
    logic [XLEN-1:0] csr_new_s;
    logic [XLEN-1:0] mstatus_val_s;
    logic [XLEN-1:0] mie_val_s;
    logic [XLEN-1:0] mip_val_s;
    logic            mapped_s;
    logic            readonly_s;
    logic            writes_s;
    logic            illegal_s;
    logic            wr_en_s;
    logic [XLEN-1:0] cause_s;
    logic [XLEN-1:0] trap_vec_s;

    // Address decode: old value, mapping and legality of the current request.
    always_comb begin
        mstatus_val_s     = {XLEN{1'b0}};
        mstatus_val_s[3]  = mstatus_mie_q;
        mstatus_val_s[7]  = mstatus_mpie_q;
        mstatus_val_s[12:11] = 2'b11;
        mie_val_s         = {XLEN{1'b0}};
        mie_val_s[7]      = mie_mtie_q;
        mie_val_s[11]     = mie_meie_q;
        mip_val_s         = {XLEN{1'b0}};
        mip_val_s[7]      = mip_mtip_q;
        mip_val_s[11]     = mip_meip_q;
        csr_old_s         = {XLEN{1'b0}};
        mapped_s          = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:    csr_old_s = mstatus_val_s;
            ADDR_MISA:       csr_old_s = XLEN'(MISA_VAL);
            ADDR_MIE:        csr_old_s = mie_val_s;
            ADDR_MTVEC:      csr_old_s = mtvec_q;
            ADDR_MCOUNTEREN: csr_old_s = XLEN'(mcounteren_q);
            ADDR_MEPC:       csr_old_s = mepc_q;
            ADDR_MCAUSE:     csr_old_s = mcause_q;
            ADDR_MIP:        csr_old_s = mip_val_s;
            ADDR_MCYCLE:     csr_old_s = mcycle_q[XLEN-1:0];
            ADDR_MINSTRET:   csr_old_s = minstret_q[XLEN-1:0];
            ADDR_MCYCLEH: begin
                csr_old_s = XLEN'(mcycle_q[63:32]);
                mapped_s  = (XLEN == 32'd32);
            end
            ADDR_MINSTRETH: begin
                csr_old_s = XLEN'(minstret_q[63:32]);
                mapped_s  = (XLEN == 32'd32);
            end
            ADDR_MVENDORID:  csr_old_s = {XLEN{1'b0}};
            ADDR_MARCHID:    csr_old_s = XLEN'(ARCH_ID);
            ADDR_MIMPID:     csr_old_s = XLEN'(IMP_ID);
            ADDR_MHARTID:    csr_old_s = XLEN'(HART_ID);
            default:         mapped_s  = 1'b0;
        endcase

        case (csr_op_i)
            OP_RW:   csr_new_s = csr_wdata_i;
            OP_RS:   csr_new_s = csr_old_s | csr_wdata_i;
            OP_RC:   csr_new_s = csr_old_s & ~csr_wdata_i;
            default: csr_new_s = csr_old_s;
        endcase

        // Set/clear with a zero mask is a pure read, so it is legal on read-only CSRs.
        readonly_s = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == ADDR_MIP);
        writes_s   = (csr_op_i == OP_RW) ||
                     (((csr_op_i == OP_RS) || (csr_op_i == OP_RC)) && (|csr_wdata_i));
        illegal_s  = !mapped_s || (readonly_s && writes_s);
        wr_en_s    = csr_req_i && !illegal_s && writes_s && (csr_op_i != OP_READ);
    end

    // Next-state for every CSR; trap beats mret beats a software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mcounteren_d   = mcounteren_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q;
        mip_meip_d     = irq_ext_i;
        mip_mtip_d     = irq_timer_i;

        if (trap_i) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en_s && (csr_addr_i == ADDR_MSTATUS)) begin
            mstatus_mie_d  = csr_new_s[3];
            mstatus_mpie_d = csr_new_s[7];
        end else begin
            mstatus_mie_d  = mstatus_mie_q;
        end

        if (trap_i) begin
            mepc_d   = align4(trap_pc_i);
            mcause_d = trap_cause_i;
        end else if (wr_en_s && (csr_addr_i == ADDR_MEPC)) begin
            mepc_d   = align4(csr_new_s);
        end else if (wr_en_s && (csr_addr_i == ADDR_MCAUSE)) begin
            mcause_d = csr_new_s;
        end else begin
            mepc_d   = mepc_q;
        end

        if (wr_en_s && (csr_addr_i == ADDR_MIE)) begin
            mie_meie_d = csr_new_s[11];
            mie_mtie_d = csr_new_s[7];
        end else if (wr_en_s && (csr_addr_i == ADDR_MTVEC)) begin
            mtvec_d = mtvec_warl(mtvec_q[1:0], csr_new_s);
        end else if (wr_en_s && (csr_addr_i == ADDR_MCOUNTEREN)) begin
            mcounteren_d = csr_new_s[31:0];
        end else begin
            mtvec_d = mtvec_q;
        end

        // A write to one half replaces this cycle's increment and leaves the other half alone.
        if (wr_en_s && (csr_addr_i == ADDR_MCYCLE)) begin
            mcycle_d = mcycle_q;
            mcycle_d[XLEN-1:0] = csr_new_s;
        end else if (wr_en_s && (csr_addr_i == ADDR_MCYCLEH)) begin
            mcycle_d = mcycle_q;
            mcycle_d[63:32] = csr_new_s[31:0];
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end

        if (wr_en_s && (csr_addr_i == ADDR_MINSTRET)) begin
            minstret_d[XLEN-1:0] = csr_new_s;
        end else if (wr_en_s && (csr_addr_i == ADDR_MINSTRETH)) begin
            minstret_d[63:32] = csr_new_s[31:0];
        end else if (instret_i) begin
            minstret_d = minstret_q + 64'd1;
        end else begin
            minstret_d = minstret_q;
        end

        ack_d         = csr_req_i;
        illegal_d     = csr_req_i && illegal_s;
        rdata_d       = (csr_req_i && !illegal_s) ? csr_old_s : {XLEN{1'b0}};
        irq_pending_d = mstatus_mie_q && ((mip_meip_q && mie_meie_q) ||
                                          (mip_mtip_q && mie_mtie_q));
    end

    // Vectored mode offsets interrupts only; exceptions always go to BASE.
    always_comb begin
        cause_s = trap_i ? trap_cause_i : mcause_q;
        if ((mtvec_q[1:0] == 2'b01) && cause_s[XLEN-1]) begin
            trap_vec_s = align4(mtvec_q) + (cause_s << 2'd2);
        end else begin
            trap_vec_s = align4(mtvec_q);
        end
    end

    // State and registered response flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mcounteren_q   <= 32'd0;
            mepc_q         <= {XLEN{1'b0}};
            mcause_q       <= {XLEN{1'b0}};
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
            ack_q          <= 1'b0;
            rdata_q        <= {XLEN{1'b0}};
            illegal_q      <= 1'b0;
            irq_pending_q  <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mip_meip_q     <= mip_meip_d;
            mip_mtip_q     <= mip_mtip_d;
            mtvec_q        <= mtvec_d;
            mcounteren_q   <= mcounteren_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            ack_q          <= ack_d;
            rdata_q        <= rdata_d;
            illegal_q      <= illegal_d;
            irq_pending_q  <= irq_pending_d;
        end
    end

    assign csr_ack_o     = ack_q;
    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = illegal_q;
    assign irq_pending_o = irq_pending_q;
    assign trap_vec_o    = trap_vec_s;
    assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_scr1_csr_unit.sv
// Directed bench for scr1_csr_unit: inputs change on the falling edge, outputs are
// checked on the falling edge after each rising edge.
module tb_scr1_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        illegal;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] pc;
    logic        mret;
    logic        instret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_pending;
    logic [31:0] trap_vec;
    logic [31:0] mepc;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    always #5 clk = ~clk;

    scr1_csr_unit #(
        .XLEN      (32),
        .HART_ID   (3),
        .MISA_VAL  (32'h4000_0100),
        .ARCH_ID   (0),
        .IMP_ID    (1),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .csr_req_i     (req),
        .csr_op_i      (op),
        .csr_addr_i    (addr),
        .csr_wdata_i   (wdata),
        .csr_ack_o     (ack),
        .csr_rdata_o   (rdata),
        .csr_illegal_o (illegal),
        .trap_i        (trap),
        .trap_cause_i  (cause),
        .trap_pc_i     (pc),
        .mret_i        (mret),
        .instret_i     (instret),
        .irq_ext_i     (irq_ext),
        .irq_timer_i   (irq_timer),
        .irq_pending_o (irq_pending),
        .trap_vec_o    (trap_vec),
        .mepc_o        (mepc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access: driven before a rising edge, returns on the following falling edge.
    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; op = RD; addr = 12'h000; wdata = 32'd0;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr(RD, a, 32'd0);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        chk(tag, rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; op = RD; addr = 12'h000; wdata = 32'd0;
        trap = 1'b0; cause = 32'd0; pc = 32'd0; mret = 1'b0; instret = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_trap_vec", trap_vec, 32'd0);
        chk("rst_mepc", mepc, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        csr(RD, 12'hF14, 32'd0);
        chk("hartid_ack", {31'd0, ack}, 32'd1);
        chk("hartid", rdata, 32'd3);
        chk("hartid_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("ack_pulse", {31'd0, ack}, 32'd0);
        read_chk("misa", 12'h301, 32'h4000_0100);
        read_chk("mimpid", 12'hF13, 32'd1);
        read_chk("mstatus_rst", 12'h300, 32'h0000_1800);

        // mtvec WARL: reserved MODE keeps old MODE, BASE always written.
        csr(RW, 12'h305, 32'h8000_0003);
        chk("mtvec_old", rdata, 32'd0);
        read_chk("mtvec_mode_kept", 12'h305, 32'h8000_0000);
        csr(RW, 12'h305, 32'h0000_0201);
        chk("mtvec_old2", rdata, 32'h8000_0000);
        read_chk("mtvec_vectored", 12'h305, 32'h0000_0201);
        chk("trap_vec_exc", trap_vec, 32'h0000_0200);

        csr(RS, 12'h300, 32'h0000_0008);
        chk("mstatus_rs_old", rdata, 32'h0000_1800);
        read_chk("mstatus_mie", 12'h300, 32'h0000_1808);

        trap = 1'b1; cause = 32'h8000_000B; pc = 32'h0000_0100;
        #1;
        chk("trap_vec_during", trap_vec, 32'h0000_022C);
        @(negedge clk);
        trap = 1'b0; cause = 32'd0; pc = 32'd0;
        chk("mepc_after_trap", mepc, 32'h0000_0100);
        chk("trap_vec_after", trap_vec, 32'h0000_022C);
        read_chk("mstatus_trap", 12'h300, 32'h0000_1880);
        read_chk("mcause", 12'h342, 32'h8000_000B);
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        read_chk("mstatus_mret", 12'h300, 32'h0000_1888);

        csr(RW, 12'hF11, 32'd5);
        chk("ro_rw_illegal", {31'd0, illegal}, 32'd1);
        chk("ro_rw_rdata", rdata, 32'd0);
        chk("ro_rw_ack", {31'd0, ack}, 32'd1);
        csr(RD, 12'h7C0, 32'd0);
        chk("unmapped_illegal", {31'd0, illegal}, 32'd1);
        csr(RS, 12'hF11, 32'd0);
        chk("ro_rs0_legal", {31'd0, illegal}, 32'd0);
        csr(RS, 12'hF14, 32'd1);
        chk("ro_rs1_illegal", {31'd0, illegal}, 32'd1);
        chk("ro_rs1_rdata", rdata, 32'd0);
        csr(RW, 12'h344, 32'h0000_0080);
        chk("mip_rw_illegal", {31'd0, illegal}, 32'd1);
        read_chk("hartid_unchanged", 12'hF14, 32'd3);

        csr(RW, 12'h341, 32'h0001_2347);
        read_chk("mepc_align", 12'h341, 32'h0001_2344);
        chk("mepc_o", mepc, 32'h0001_2344);

        // Counter boundary: low half wraps into high half after the writes settle.
        csr(RW, 12'hB00, 32'hFFFF_FFFF);
        csr(RW, 12'hB80, 32'd0);
        read_chk("mcycleh_before_carry", 12'hB80, 32'd0);
        read_chk("mcycleh_carry", 12'hB80, 32'd1);
        read_chk("mcycle_low", 12'hB00, 32'd1);

        instret = 1'b1;
        csr(RW, 12'hB02, 32'd5);
        read_chk("minstret_write_wins", 12'hB02, 32'd5);
        read_chk("minstret_inc", 12'hB02, 32'd6);
        instret = 1'b0;
        read_chk("minstret_hold", 12'hB02, 32'd7);
        read_chk("minstret_hold2", 12'hB02, 32'd7);

        csr(RS, 12'h304, 32'h0000_0080);
        irq_timer = 1'b1;
        @(negedge clk);
        chk("irq_pend_1cyc", {31'd0, irq_pending}, 32'd0);
        @(negedge clk);
        chk("irq_pend_2cyc", {31'd0, irq_pending}, 32'd1);
        read_chk("mip_mtip", 12'h344, 32'h0000_0080);
        csr(RC, 12'h300, 32'h0000_0008);
        @(negedge clk);
        chk("irq_pend_mie_clr", {31'd0, irq_pending}, 32'd0);
        irq_timer = 1'b0;

        // Collision: trap owns mepc this cycle, the CSR still acks the old value.
        trap = 1'b1; cause = 32'h0000_0002; pc = 32'h0000_0300;
        csr(RW, 12'h341, 32'h0000_4444);
        trap = 1'b0; cause = 32'd0; pc = 32'd0;
        chk("collide_ack", {31'd0, ack}, 32'd1);
        chk("collide_old", rdata, 32'h0001_2344);
        chk("collide_mepc", mepc, 32'h0000_0300);
        chk("trap_vec_exc_mode1", trap_vec, 32'h0000_0200);

        // Reset in the middle of an access drops the ack and clears state.
        req = 1'b1; op = RD; addr = 12'hF14;
        #2 rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0; addr = 12'h000;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_mepc", mepc, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("midrst_mtvec", 12'h305, 32'd0);
        read_chk("midrst_mstatus", 12'h300, 32'h0000_1800);
        read_chk("midrst_mcycleh", 12'hB80, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
